// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed 7-segment scan controller.
//
// Drives NUM_DIGITS digit positions from one shared segment bus. Each
// digit slot is BLANK_CYCLES of all-off followed by DWELL_CYCLES of drive.
// A display word is loaded through a valid/ready handshake into a shadow
// buffer. That buffer is copied to the active register only at a frame
// wrap, or at once while scanning is disabled.
//
// Optional build macro: SEG_SCAN_LZ_SUPPRESS_EN enables leading-zero
// suppression. Digits above the most significant nonzero digit are blanked
// while their an bit still toggles. Digit 0 is always shown.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   scan enable; low blanks the display
//   load_valid   in   new display word offered
//   load_ready   out  shadow buffer free
//   load_digits  in   4-bit hex code per digit, digit 0 in bits [3:0]
//   load_dp      in   decimal point per digit
//   an           out  one-hot digit enable (all zero while blanking)
//   seg          out  segments {g,f,e,d,c,b,a}, active-high
//   dp           out  decimal point, active-high
//   frame_tick   out  one-cycle pulse in the first cycle of each new frame
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 12000,
  parameter int BLANK_CYCLES = 600
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_wrap;

  logic [4*NUM_DIGITS-1:0] r_active_digits;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic                    w_accept;
  logic                    w_commit;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_tick;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [3:0]              w_digit_nxt;
  logic                    w_suppress;
  logic [IDX_W-1:0]        w_msnz;

  function automatic logic [6:0] f_decode(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Next-state logic; enable low forces the scan back to BLANK, idx 0.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_wrap      = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_BLANK;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          if (r_cnt == CNT_W'(DWELL_CYCLES - 1)) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
              w_idx_nxt = '0;
              w_wrap    = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Most significant nonzero digit of the active word (0 when all zero).
  always_comb begin
    w_msnz = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_active_digits[4*i +: 4] != 4'h0) w_msnz = IDX_W'(i);
    end
  end

  assign w_digit_nxt = r_active_digits[{w_idx_nxt, 2'b00} +: 4];

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  assign w_suppress = (w_idx_nxt > w_msnz);
`else
  assign w_suppress = 1'b0;
`endif

  // Outputs are registered from the next state, so they line up with the
  // state register without a pipeline stage. The active register never
  // changes on an edge that enters or stays in DRIVE, so reading it here
  // matches what the following cycle holds.
  always_comb begin
    w_an_nxt  = '0;
    w_seg_nxt = '0;
    w_dp_nxt  = 1'b0;
    if (w_state_nxt == ST_DRIVE) begin
      w_an_nxt[w_idx_nxt] = 1'b1;
      w_seg_nxt           = w_suppress ? 7'b0000000 : f_decode(w_digit_nxt);
      w_dp_nxt            = r_active_dp[w_idx_nxt];
    end
  end

  // The commit lands at the end of the frame_tick cycle. This keeps
  // load_ready low during that cycle, so a load offered there is taken one
  // cycle later. A load and a commit can never share an edge.
  assign w_accept = load_valid && !r_pending;
  assign w_commit = r_pending && (!enable || r_frame_tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_an         <= '0;
      r_seg        <= '0;
      r_dp         <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_tick <= w_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_digits <= '0;
      r_active_dp     <= '0;
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      r_pending       <= 1'b0;
    end else begin
      if (w_commit) begin
        r_active_digits <= r_shadow_digits;
        r_active_dp     <= r_shadow_dp;
        r_pending       <= 1'b0;
      end
      if (w_accept) begin
        r_shadow_digits <= load_digits;
        r_shadow_dp     <= load_dp;
        r_pending       <= 1'b1;
      end
    end
  end

  assign load_ready = !r_pending;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int SL = BL + DW;
  localparam int FR = ND * SL;
  localparam int NCYC = 3000;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_digits;
  logic [ND-1:0]   load_dp;
  logic [ND-1:0]   an;
  logic [6:0]      seg;
  logic            dp;
  logic            frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_digits(load_digits),
    .load_dp    (load_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          tick;
    logic          rdy;
  } obs_t;

  obs_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: position within the frame plus display/shadow words.
  int              m_p;
  logic [4*ND-1:0] m_act, m_sh;
  logic [ND-1:0]   m_actdp, m_shdp;
  logic            m_pend, m_tick;

  function automatic obs_t expect_now();
    obs_t e;
    int   slot, idx, dig, top;
    e      = '0;
    e.tick = m_tick;
    e.rdy  = !m_pend;
    slot   = m_p % SL;
    idx    = m_p / SL;
    if (slot >= BL) begin
      e.an[idx] = 1'b1;
      dig       = int'((m_act >> (4 * idx)) & 16'hF);
      e.seg     = SEG_TAB[dig];
      e.dp      = m_actdp[idx];
      top = 0;
      for (int i = 0; i < ND; i++)
        if (((m_act >> (4 * i)) & 16'hF) != 0) top = i;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
      if (idx > top) e.seg = 7'b0000000;
`endif
    end
    return e;
  endfunction

  function automatic obs_t actual_now();
    obs_t a;
    a.an   = an;
    a.seg  = seg;
    a.dp   = dp;
    a.tick = frame_tick;
    a.rdy  = load_ready;
    return a;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: advance on every rising edge and queue the expected outputs.
  always @(posedge clk) begin
    logic acc;
    if (!rst_n) begin
      m_p = 0; m_act = '0; m_sh = '0; m_actdp = '0; m_shdp = '0;
      m_pend = 1'b0; m_tick = 1'b0;
    end else begin
      acc = load_valid && !m_pend;
      if (m_pend && (!enable || m_tick)) begin
        m_act   = m_sh;
        m_actdp = m_shdp;
        m_pend  = 1'b0;
      end
      if (acc) begin
        m_sh   = load_digits;
        m_shdp = load_dp;
        m_pend = 1'b1;
      end
      if (!enable) begin
        m_p    = 0;
        m_tick = 1'b0;
      end else begin
        m_p    = (m_p + 1) % FR;
        m_tick = (m_p == 0);
      end
    end
    q.push_back(expect_now());
  end

  // Monitor: one observation per cycle, compared against the queue head.
  initial begin
    obs_t e, a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      a = actual_now();
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scan_out cyc %0d: no expected entry queued", cyc);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL scan_out cyc %0d: an=%b seg=%b dp=%b tick=%b rdy=%b, expected an=%b seg=%b dp=%b tick=%b rdy=%b",
                   cyc, a.an, a.seg, a.dp, a.tick, a.rdy, e.an, e.seg, e.dp, e.tick, e.rdy);
        end
      end
    end
  end

  task automatic check_async_reset(input string name);
    obs_t a, e;
    a = actual_now();
    e = '0;
    e.rdy = 1'b1;
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: an=%b seg=%b dp=%b tick=%b rdy=%b, expected all zero with rdy=1",
               name, a.an, a.seg, a.dp, a.tick, a.rdy);
    end
  endtask

  // Driver: inputs change 2 time units after the falling edge.
  initial begin
    int         dis_cnt;
    logic [15:0] rnd;
    dis_cnt     = 0;
    rst_n       = 1'b1;
    enable      = 1'b0;
    load_valid  = 1'b0;
    load_digits = '0;
    load_dp     = '0;
    #1 rst_n = 1'b0;
    #1 check_async_reset("reset_state");
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    enable = 1'b1;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      #2;
      if (cyc == 1201 || cyc == 2401) rst_n = 1'b1;

      if (dis_cnt == 0 && cyc > 60 && $urandom_range(0, 79) == 0)
        dis_cnt = $urandom_range(1, 8);
      enable = (dis_cnt == 0);
      if (dis_cnt > 0) dis_cnt--;

      if (!(load_valid && !load_ready)) begin
        load_valid  = (cyc >= 50) && ($urandom_range(0, 5) == 0);
        rnd         = 16'($urandom);
        load_digits = rnd >> (4 * $urandom_range(0, 4));
        load_dp     = 4'($urandom);
      end

      if (cyc == 1200 || cyc == 2400) begin
        rst_n = 1'b0;
        #1 check_async_reset("async_reset");
        q.delete();
      end
    end
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
